// File: rtl/csr_pkg.sv
// csr_pkg: shared constants, state encoding and layout helpers for the CSR
// tile decoder.
//   DIM/DW/CW/PW        tile size, element, column-index and pointer widths
//   PTR_W / MAT_W       packed pointer word and dense tile widths
//   CSR_ZERO_SENTINEL   pointer word meaning "all-zero tile"
//   csr_state_t         decoder FSM states
//   ptr_lsb/ptr_field   pointer field extraction (P0 sits just below the pad byte)
//   elem_lsb            LSB of element [r][c] in the packed dense tile
package csr_pkg;

  localparam int DIM   = 6;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int PW    = 8;
  localparam int CNT_W = 6;
  localparam int PTR_W = PW * (DIM + 1);
  localparam int MAT_W = DIM * DIM * DW;

  localparam logic [PTR_W-1:0] CSR_ZERO_SENTINEL = 56'h01010101010101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } csr_state_t;

  // Pr lives at bits [(DIM-1-r)*PW +: PW]; P0 is the most significant field
  // below the zero pad byte.
  function automatic int ptr_lsb(input logic [2:0] r);
    return (DIM - 1 - int'(r)) * PW;
  endfunction

  function automatic logic [PW-1:0] ptr_field(input logic [PTR_W-1:0] p,
                                              input logic [2:0] r);
    return PW'(p >> ptr_lsb(r));
  endfunction

  // Element [0][0] occupies the top byte of the tile.
  function automatic int elem_lsb(input logic [2:0] r, input logic [2:0] c);
    return MAT_W - DW * (DIM * int'(r) + int'(c)) - DW;
  endfunction

endpackage

// File: rtl/csr_row_locator.sv
// csr_row_locator: combinational target-row search for the CSR decoder.
//   ptr       latched 56-bit row-pointer word
//   elem_cnt  number of elements already accepted in this tile
//   row_size  active rows of the tile
//   row       smallest r < row_size with elem_cnt < Pr
//   found     a target row exists
//   mono_err  some active Pr is below Pr-1
module csr_row_locator
  import csr_pkg::*;
(
  input  logic [PTR_W-1:0] ptr,
  input  logic [CNT_W-1:0] elem_cnt,
  input  logic [3:0]       row_size,
  output logic [2:0]       row,
  output logic             found,
  output logic             mono_err
);

  logic [PW-1:0] p [DIM];

  always_comb begin
    for (int r = 0; r < DIM; r++) begin
      p[r] = ptr_field(ptr, 3'(r));
    end
  end

  // Scanning from the last row down leaves the smallest qualifying row;
  // empty rows (Pr == Pr-1) never qualify, so they are skipped.
  always_comb begin
    row   = '0;
    found = 1'b0;
    for (int r = DIM - 1; r >= 0; r--) begin
      if ((4'(r) < row_size) && (PW'(elem_cnt) < p[r])) begin
        row   = 3'(r);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    mono_err = 1'b0;
    for (int r = 1; r < DIM; r++) begin
      if ((4'(r) < row_size) && (p[r] < p[r-1])) begin
        mono_err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_decoder.sv
// csr_decoder: rebuilds a dense 6x6 int8 tile from a CSR row-pointer word and
// a strobed stream of (value, column) pairs.
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse, accepted only in IDLE
//   row_size       active rows/cols (1..6), sampled with start
//   index_pointer  {8'h00, P0..P5} cumulative nonzero counts, sampled with start
//   store/data/col element strobe with value and column index
//   matrix_out     dense tile, element [r][c] at [287-8*(6r+c) -: 8]
//   busy           high in LOAD and FILL
//   done           one-cycle pulse when matrix_out is complete
//   err            sticky per tile, cleared by the next accepted start
//   fsm_state      current FSM state (debug visibility)
//
// Handshake: there is no back-pressure. An element is consumed on every rising
// edge where store=1 and the decoder is in FILL; store outside FILL is
// dropped. done is high for exactly the cycle after the edge that consumes the
// last element, and a start in the following cycle is accepted.
module csr_decoder
  import csr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         row_size,
  input  logic [PTR_W-1:0]   index_pointer,
  input  logic               store,
  input  logic [DW-1:0]      data,
  input  logic [CW-1:0]      col,
  output logic [MAT_W-1:0]   matrix_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         fsm_state
);

  csr_state_t         state_q, state_d;
  logic [3:0]         row_size_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PW-1:0]      total_q;
  logic               zero_mode_q;
  logic [CNT_W-1:0]   elem_cnt_q;
  logic               err_q;
  logic [MAT_W-1:0]   matrix_q;

  logic               size_ok;
  logic               is_sentinel;
  logic [PW-1:0]      total_load;
  logic               last_elem;
  logic               col_ok;
  logic [2:0]         tgt_row;
  logic               tgt_found;
  logic               mono_err;

  csr_row_locator u_row_locator (
    .ptr      (ptr_q),
    .elem_cnt (elem_cnt_q),
    .row_size (row_size_q),
    .row      (tgt_row),
    .found    (tgt_found),
    .mono_err (mono_err)
  );

  always_comb begin
    size_ok     = (row_size_q != 4'd0) && (row_size_q <= 4'(DIM));
    is_sentinel = (ptr_q == CSR_ZERO_SENTINEL);
    total_load  = '0;
    // The sentinel tile still consumes a single dummy element.
    if (is_sentinel) begin
      total_load = PW'(1);
    end else if (size_ok) begin
      total_load = ptr_field(ptr_q, 3'(row_size_q - 4'd1));
    end
    last_elem = ((PW'(elem_cnt_q) + PW'(1)) == total_q);
    col_ok    = (col < row_size_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (!size_ok)                state_d = DONE;
        else if (is_sentinel)        state_d = FILL;
        else if (total_load == '0)   state_d = DONE;
        else                         state_d = FILL;
      end
      FILL: begin
        if (mono_err)                state_d = DONE;
        else if (store && last_elem) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q == LOAD) || (state_q == FILL);
    done      = (state_q == DONE);
    fsm_state = state_q;
  end

  // Datapath: latched tile parameters, element counter, error flag, tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_size_q  <= '0;
      ptr_q       <= '0;
      total_q     <= '0;
      zero_mode_q <= 1'b0;
      elem_cnt_q  <= '0;
      err_q       <= 1'b0;
      matrix_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            row_size_q <= row_size;
            ptr_q      <= index_pointer;
            err_q      <= 1'b0;
          end
        end
        LOAD: begin
          matrix_q    <= '0;
          elem_cnt_q  <= '0;
          total_q     <= total_load;
          zero_mode_q <= is_sentinel;
          if (!size_ok) err_q <= 1'b1;
        end
        FILL: begin
          if (mono_err) begin
            err_q <= 1'b1;
          end else if (store) begin
            // Zero-valued elements are still written; duplicates overwrite.
            if (col_ok && !zero_mode_q && tgt_found) begin
              matrix_q[elem_lsb(tgt_row, col[2:0]) +: DW] <= data;
            end
            if (!col_ok) err_q <= 1'b1;
            elem_cnt_q <= elem_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign matrix_out = matrix_q;
  assign err        = err_q;

endmodule

// File: tb/tb_csr_decoder.sv
module tb_csr_decoder;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   row_size;
  logic [55:0]  index_pointer;
  logic         store;
  logic [7:0]   data;
  logic [3:0]   col;
  logic [287:0] matrix_out;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   fsm_state;

  csr_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .row_size      (row_size),
    .index_pointer (index_pointer),
    .store         (store),
    .data          (data),
    .col           (col),
    .matrix_out    (matrix_out),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [288:0] exp_q[$];     // {err, matrix} expected at each done
  logic [7:0]   el_data[$];
  logic [3:0]   el_col[$];
  logic [287:0] exp_mat;

  task automatic check(input string name, input logic [287:0] act,
                       input logic [287:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic put(input int r, input int c, input logic [7:0] v);
    exp_mat[280 - 8 * (6 * r + c) +: 8] = v;
  endtask

  task automatic add_el(input logic [7:0] v, input logic [3:0] c);
    el_data.push_back(v);
    el_col.push_back(c);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [288:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending tile");
      end else begin
        e = exp_q.pop_front();
        check("matrix_out", matrix_out, e[287:0]);
        check("err_at_done", {287'd0, err}, {287'd0, e[288]});
        check("busy_at_done", {287'd0, busy}, 288'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // exp_delay: edges between the last stimulus edge and done being visible.
  task automatic run_tile(input logic [3:0] rs, input logic [55:0] ptr,
                          input logic exp_err, input int exp_delay,
                          input string name);
    int k;
    exp_q.push_back({exp_err, exp_mat});
    row_size      = rs;
    index_pointer = ptr;
    start         = 1'b1;
    @(posedge clk); #1;
    start         = 1'b0;
    row_size      = 4'd0;
    index_pointer = 56'h0;
    @(posedge clk); #1;
    for (int i = 0; i < el_data.size(); i++) begin
      if (i == 0) check({name, "_busy"}, {287'd0, busy}, {287'd0, 1'b1});
      store = 1'b1;
      data  = el_data[i];
      col   = el_col[i];
      @(posedge clk); #1;
    end
    store = 1'b0;
    data  = 8'h0;
    col   = 4'h0;
    k = 0;
    while (!done && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 8 cycles", name);
    end else begin
      check({name, "_done_latency"}, 288'(k), 288'(exp_delay));
    end
    @(posedge clk); #1;
    check({name, "_done_width"}, {287'd0, done}, 288'd0);
    el_data.delete();
    el_col.delete();
  endtask

  task automatic encode_random(input int rs, input int density,
                               output logic [55:0] ptr);
    int cnt;
    logic [7:0] v;
    cnt     = 0;
    ptr     = 56'h0;
    exp_mat = '0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (r < rs && c < rs && $urandom_range(1, 100) <= density) begin
          v = 8'($urandom_range(1, 255));
          put(r, c, v);
          add_el(v, 4'(c));
          cnt++;
        end
      end
      ptr[(5 - r) * 8 +: 8] = 8'(cnt);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [55:0] rptr;
    int          rs;
    rst_n         = 1'b0;
    start         = 1'b0;
    row_size      = 4'd0;
    index_pointer = 56'h0;
    store         = 1'b0;
    data          = 8'h0;
    col           = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_matrix", matrix_out, 288'd0);
    check("reset_busy", {287'd0, busy}, 288'd0);
    check("reset_done", {287'd0, done}, 288'd0);
    check("reset_err", {287'd0, err}, 288'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Dense single row 2
    exp_mat = '0;
    for (int c = 0; c < 6; c++) begin
      put(2, c, 8'(c + 1));
      add_el(8'(c + 1), 4'(c));
    end
    run_tile(4'd6, 56'h00_00_00_06_06_06_06, 1'b0, 0, "dense_row");

    // Empty row 1 skipped
    exp_mat = '0;
    put(0, 1, 8'h11); put(2, 0, 8'h22); put(2, 2, 8'h33);
    add_el(8'h11, 4'd1); add_el(8'h22, 4'd0); add_el(8'h33, 4'd2);
    run_tile(4'd3, 56'h00_01_01_03_03_03_03, 1'b0, 0, "empty_row");

    // All-zero sentinel
    exp_mat = '0;
    add_el(8'h00, 4'd0);
    run_tile(4'd6, 56'h01_01_01_01_01_01_01, 1'b0, 0, "sentinel");

    // Bad column among valid ones
    exp_mat = '0;
    put(0, 0, 8'hA1); put(1, 2, 8'hA3); put(2, 3, 8'hA4);
    add_el(8'hA1, 4'd0); add_el(8'hA2, 4'd5); add_el(8'hA3, 4'd2); add_el(8'hA4, 4'd3);
    run_tile(4'd4, 56'h00_02_03_04_04_04_04, 1'b1, 0, "bad_col");
    check("err_sticky", {287'd0, err}, {287'd0, 1'b1});

    // Empty tile (total 0); also shows err cleared by the new start
    exp_mat = '0;
    run_tile(4'd6, 56'h0, 1'b0, 0, "empty_tile");

    // Illegal row sizes
    exp_mat = '0;
    run_tile(4'd0, 56'h00_01_01_01_01_01_01, 1'b1, 0, "rs_zero");
    exp_mat = '0;
    run_tile(4'd7, 56'h00_01_02_03_04_05_06, 1'b1, 0, "rs_seven");

    // Non-monotonic pointer aborts on the first FILL cycle
    exp_mat = '0;
    run_tile(4'd6, 56'h00_03_01_04_04_04_04, 1'b1, 1, "non_mono");

    // Duplicate write overwrites
    exp_mat = '0;
    put(0, 1, 8'h66);
    add_el(8'h55, 4'd1); add_el(8'h66, 4'd1);
    run_tile(4'd2, 56'h00_02_02_02_02_02_02, 1'b0, 0, "dup_write");

    // Reset in the middle of FILL
    row_size      = 4'd6;
    index_pointer = 56'h00_05_05_05_05_05_05;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    store = 1'b1; data = 8'h01; col = 4'd0;
    @(posedge clk); #1;
    data = 8'h02; col = 4'd1;
    @(posedge clk); #1;
    store = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midreset_matrix", matrix_out, 288'd0);
    check("midreset_busy", {287'd0, busy}, 288'd0);
    check("midreset_done", {287'd0, done}, 288'd0);
    check("midreset_state", {286'd0, fsm_state}, 288'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery tile
    exp_mat = '0;
    put(0, 0, 8'h7F); put(5, 5, 8'h80);
    add_el(8'h7F, 4'd0); add_el(8'h80, 4'd5);
    run_tile(4'd6, 56'h00_01_01_01_01_01_02, 1'b0, 0, "after_reset");

    // Round trip through a reference encoder, back-to-back starts
    for (int t = 0; t < 6; t++) begin
      rs = (t == 0) ? 6 : $urandom_range(1, 6);
      encode_random(rs, 100 - 18 * t, rptr);
      run_tile(4'(rs), rptr, 1'b0, 0, "round_trip");
    end

    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_tiles: got %0d outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
